// File: rtl/wb_stage_buffered.sv
// Writeback stage: selects ALU/load/link result, queues register-file writes in a
// DEPTH-entry FIFO, offers forwarding over pending writes and counts retirements.
module wb_stage_buffered #(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 4,
   parameter int LINK_REG = 15,
   parameter int PC_INC   = 1,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [RA_W-1:0]   rd_in,
   input  logic              wb_en_in,
   input  logic              is_ld_in,
   input  logic              is_call_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] ld_res_in,
   input  logic              rf_grant,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [RA_W-1:0]   fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic              sel_err
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [RA_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic              sel_err_q, sel_err_d;

   logic              empty, accept, sel_legal, push, pop;
   logic [RA_W-1:0]   push_addr;
   logic [DATA_W-1:0] push_data;

   assign empty     = (count_q == '0);
   assign in_ready  = !rst && (count_q < (PTR_W+1)'(DEPTH));
   assign accept    = in_valid && in_ready;
   assign sel_legal = !(is_ld_in && is_call_in);
   assign push      = accept && wb_en_in && sel_legal;
   // Write strobe is suppressed during reset so nothing leaks out of a queue being flushed.
   assign pop       = !rst && !empty && rf_grant;

   always_comb begin
      push_addr = rd_in;
      push_data = alu_res_in;
      if (is_call_in) begin
         push_addr = RA_W'(LINK_REG);
         push_data = pc_in + DATA_W'(PC_INC);
      end else if (is_ld_in) begin
         push_data = ld_res_in;
      end
   end

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      retire_cnt_d = retire_cnt_q;
      sel_err_d    = sel_err_q;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (accept) begin
         retire_cnt_d = retire_cnt_q + 1'b1;
         if (!sel_legal) sel_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         retire_cnt_q <= '0;
         sel_err_q    <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         retire_cnt_q <= retire_cnt_d;
         sel_err_q    <= sel_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= push_addr;
         data_q[wr_ptr_q] <= push_data;
      end
   end

   assign rf_we      = pop;
   assign rf_waddr   = empty ? '0 : addr_q[rd_ptr_q];
   assign rf_wdata   = empty ? '0 : data_q[rd_ptr_q];
   assign retire_cnt = retire_cnt_q;
   assign sel_err    = sel_err_q;

   // Walk entries oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < count_q) && (addr_q[rd_ptr_q + PTR_W'(i)] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Bench for wb_stage_buffered: directed vector table, hand sequences, and random traffic
// compared against a queue-based model of the stage.
module tb_wb_stage_buffered;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] pc_in = '0;
   logic [3:0]  rd_in = '0;
   logic        wb_en_in = 1'b0;
   logic        is_ld_in = 1'b0;
   logic        is_call_in = 1'b0;
   logic [31:0] alu_res_in = '0;
   logic [31:0] ld_res_in = '0;
   logic        rf_grant = 1'b0;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [3:0]  fwd_addr = '0;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [31:0] retire_cnt;
   logic        sel_err;

   wb_stage_buffered #(
      .DATA_W(32), .RA_W(4), .LINK_REG(15), .PC_INC(1), .DEPTH(4), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
      .rd_in(rd_in), .wb_en_in(wb_en_in), .is_ld_in(is_ld_in), .is_call_in(is_call_in),
      .alu_res_in(alu_res_in), .ld_res_in(ld_res_in), .rf_grant(rf_grant), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
      .fwd_data(fwd_data), .retire_cnt(retire_cnt), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [3:0] rd, input logic wb, input logic ld,
                         input logic call, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] ldr, input logic gnt, input logic [3:0] fa);
      in_valid = v; rd_in = rd; wb_en_in = wb; is_ld_in = ld; is_call_in = call;
      pc_in = pc; alu_res_in = alu; ld_res_in = ldr; rf_grant = gnt; fwd_addr = fa;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        v; logic [3:0] rd; logic wb; logic ld; logic call;
      logic [31:0] pc; logic [31:0] alu; logic [31:0] ldr; logic gnt; logic [3:0] fa;
      logic        e_rdy; logic e_we; logic [3:0] e_wa; logic [31:0] e_wd;
      logic        e_hit; logic [31:0] e_fd; logic [31:0] e_cnt; logic e_err;
   } vec_t;

   vec_t vecs [8];

   typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;
   ent_t mq [$];
   logic [31:0] m_cnt;
   logic        m_err;

   initial begin
      // Each row: inputs for one cycle and the combinational outputs expected before its edge.
      vecs[0] = '{1,3,1,0,0,32'h0,32'h1234,32'h0,1,3,       1,0,0,32'h0,0,32'h0,0,0};
      vecs[1] = '{1,2,1,0,1,32'h40,32'h0,32'h0,1,3,         1,1,3,32'h1234,1,32'h1234,1,0};
      vecs[2] = '{1,2,1,0,1,32'hFFFFFFFF,32'h0,32'h0,1,15,  1,1,15,32'h41,1,32'h41,2,0};
      vecs[3] = '{1,7,1,1,0,32'h0,32'h0,32'hBEEF,0,15,      1,0,15,32'h0,1,32'h0,3,0};
      vecs[4] = '{1,9,0,0,0,32'h0,32'h5,32'h0,0,7,          1,0,15,32'h0,1,32'hBEEF,4,0};
      vecs[5] = '{0,0,0,0,0,32'h0,32'h0,32'h0,1,9,          1,1,15,32'h0,0,32'h0,5,0};
      vecs[6] = '{0,0,0,0,0,32'h0,32'h0,32'h0,1,7,          1,1,7,32'hBEEF,1,32'hBEEF,5,0};
      vecs[7] = '{0,0,0,0,0,32'h0,32'h0,32'h0,1,7,          1,0,0,32'h0,0,32'h0,5,0};

      // Reset state, with in_ready forced low while rst is held.
      in_valid = 1'b1;
      #1;
      chk("rdy_in_rst", in_ready, 0);
      do_reset();
      rf_grant = 1'b1;
      #1;
      chk("rst_rdy", in_ready, 1);
      chk("rst_we", rf_we, 0);
      chk("rst_wa", rf_waddr, 0);
      chk("rst_wd", rf_wdata, 0);
      chk("rst_hit", fwd_hit, 0);
      chk("rst_fd", fwd_data, 0);
      chk("rst_cnt", retire_cnt, 0);
      chk("rst_err", sel_err, 0);

      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i].v, vecs[i].rd, vecs[i].wb, vecs[i].ld, vecs[i].call,
                vecs[i].pc, vecs[i].alu, vecs[i].ldr, vecs[i].gnt, vecs[i].fa);
         #1;
         chk($sformatf("v%0d_rdy", i), in_ready, vecs[i].e_rdy);
         chk($sformatf("v%0d_we", i), rf_we, vecs[i].e_we);
         chk($sformatf("v%0d_wa", i), rf_waddr, vecs[i].e_wa);
         chk($sformatf("v%0d_wd", i), rf_wdata, vecs[i].e_wd);
         chk($sformatf("v%0d_hit", i), fwd_hit, vecs[i].e_hit);
         chk($sformatf("v%0d_fd", i), fwd_data, vecs[i].e_fd);
         chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
         chk($sformatf("v%0d_err", i), sel_err, vecs[i].e_err);
         tick();
      end

      // Backpressure: fill with grant low, hold the fifth, then drain in order.
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         set_in(1, 4'(k), 1, 0, 0, 0, 32'h100 + 32'(k), 0, 0, 0);
         tick();
      end
      set_in(1, 5, 1, 0, 0, 0, 32'h105, 0, 0, 0);
      #1;
      chk("bp_full_rdy", in_ready, 0);
      tick();
      chk("bp_held_cnt", retire_cnt, 4);
      rf_grant = 1'b1;
      #1;
      chk("bp_rdy_before_pop", in_ready, 0);
      chk("bp_we1", rf_we, 1);
      chk("bp_wa1", rf_waddr, 1);
      chk("bp_wd1", rf_wdata, 32'h101);
      tick();
      chk("bp_rdy_after_pop", in_ready, 1);
      chk("bp_wa2", rf_waddr, 2);
      chk("bp_wd2", rf_wdata, 32'h102);
      tick();
      in_valid = 1'b0;
      #1;
      chk("bp_cnt5", retire_cnt, 5);
      for (int k = 3; k <= 5; k++) begin
         chk($sformatf("bp_drain_we%0d", k), rf_we, 1);
         chk($sformatf("bp_drain_wa%0d", k), rf_waddr, 4'(k));
         chk($sformatf("bp_drain_wd%0d", k), rf_wdata, 32'h100 + 32'(k));
         tick();
      end
      chk("bp_empty_we", rf_we, 0);

      // Forwarding: youngest match wins; a same-cycle push is not visible.
      do_reset();
      set_in(1, 5, 1, 0, 0, 0, 32'hA, 0, 0, 5);
      #1;
      chk("fw_same_cycle_hit", fwd_hit, 0);
      tick();
      set_in(1, 5, 1, 0, 0, 0, 32'hB, 0, 0, 5);
      tick();
      in_valid = 1'b0;
      #1;
      chk("fw_hit5", fwd_hit, 1);
      chk("fw_data5", fwd_data, 32'hB);
      fwd_addr = 4'd6;
      #1;
      chk("fw_hit6", fwd_hit, 0);
      chk("fw_data6", fwd_data, 0);

      // Illegal select: counted, flagged, nothing queued.
      set_in(1, 8, 1, 1, 1, 32'h40, 32'h77, 32'h88, 0, 15);
      tick();
      in_valid = 1'b0;
      #1;
      chk("ill_err", sel_err, 1);
      chk("ill_cnt", retire_cnt, 3);
      chk("ill_hit15", fwd_hit, 0);
      fwd_addr = 4'd8;
      #1;
      chk("ill_hit8", fwd_hit, 0);
      set_in(1, 9, 1, 0, 0, 0, 32'h99, 0, 0, 9);
      tick();
      in_valid = 1'b0;
      #1;
      chk("ill_err_sticky", sel_err, 1);
      chk("ill_cnt4", retire_cnt, 4);
      chk("ill_legal_hit", fwd_hit, 1);

      // Reset with three queued writes.
      rst = 1'b1;
      set_in(1, 1, 1, 0, 0, 0, 1, 0, 1, 5);
      #1;
      chk("mrst_we_in_rst", rf_we, 0);
      chk("mrst_rdy_in_rst", in_ready, 0);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mrst_we", rf_we, 0);
      chk("mrst_rdy", in_ready, 1);
      chk("mrst_cnt", retire_cnt, 0);
      chk("mrst_hit", fwd_hit, 0);
      chk("mrst_err", sel_err, 0);
      chk("mrst_wa", rf_waddr, 0);

      // Random traffic against the queue model.
      do_reset();
      mq.delete();
      m_cnt = 0;
      m_err = 0;
      begin
         int gprob;
         gprob = 50;
         for (int c = 0; c < 3000; c++) begin
            logic        r_rst, e_rdy, e_we, e_hit;
            logic [3:0]  e_wa;
            logic [31:0] e_wd, e_fd, dsel;
            int          sel;
            if (c % 200 == 0) gprob = $urandom_range(10, 95);
            r_rst = ($urandom_range(0, 149) == 0);
            sel   = $urandom_range(0, 7);
            rst   = r_rst;
            set_in($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 4) != 0,
                   (sel == 4 || sel == 5 || sel == 7), (sel == 6 || sel == 7),
                   ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : 32'($urandom),
                   32'($urandom), 32'($urandom), $urandom_range(0, 99) < gprob, 4'($urandom));
            @(negedge clk);
            e_rdy = !r_rst && (mq.size() < 4);
            e_we  = !r_rst && (mq.size() > 0) && rf_grant;
            if (r_rst) begin
               chk("rnd_rst_rdy", in_ready, 0);
               chk("rnd_rst_we", rf_we, 0);
            end else begin
               e_wa  = (mq.size() > 0) ? mq[0].a : 4'd0;
               e_wd  = (mq.size() > 0) ? mq[0].d : 32'd0;
               e_hit = 1'b0;
               e_fd  = 32'd0;
               for (int j = mq.size() - 1; j >= 0; j--) begin
                  if (!e_hit && mq[j].a == fwd_addr) begin
                     e_hit = 1'b1;
                     e_fd  = mq[j].d;
                  end
               end
               chk("rnd_rdy", in_ready, e_rdy);
               chk("rnd_we", rf_we, e_we);
               chk("rnd_wa", rf_waddr, e_wa);
               chk("rnd_wd", rf_wdata, e_wd);
               chk("rnd_hit", fwd_hit, e_hit);
               chk("rnd_fd", fwd_data, e_fd);
               chk("rnd_cnt", retire_cnt, m_cnt);
               chk("rnd_err", sel_err, m_err);
            end
            if (r_rst) begin
               mq.delete();
               m_cnt = 0;
               m_err = 0;
            end else begin
               if (e_we) void'(mq.pop_front());
               if (in_valid && e_rdy) begin
                  m_cnt++;
                  if (is_ld_in && is_call_in) m_err = 1'b1;
                  else if (wb_en_in) begin
                     dsel = is_call_in ? pc_in + 32'd1 : (is_ld_in ? ld_res_in : alu_res_in);
                     mq.push_back('{is_call_in ? 4'd15 : rd_in, dsel});
                  end
               end
            end
            @(posedge clk);
            #1;
         end
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
